// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, one/two-word assembly, IF/ID register, interrupt latch
//
// Purpose:
//   Owns the program counter and reads 16-bit words from an asynchronous
//   instruction memory. Assembles one-word instructions, or two-word
//   instructions (opcode + 16-bit immediate), into the IF/ID pipeline
//   register. Applies jump, flush and stall from the later stages. Latches
//   external interrupt requests until decode acknowledges them.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   imem_addr        out  word address to instruction memory (= PC)
//   imem_data        in   word at imem_addr, valid in the same cycle
//   stall            in   freeze PC, FSM, hold registers and IF/ID
//   flush            in   clear IF/ID, restart the current instruction fetch
//   jump_taken       in   redirect PC to jump_target
//   jump_target      in   redirect address
//   interrupt_signal in   external interrupt request
//   int_ack          in   decode has accepted the interrupt
//   int_pending      out  latched interrupt request
//   if_id_instr      out  opcode word
//   if_id_imm        out  immediate word (0 for one-word instructions)
//   if_id_pc         out  address of the opcode word
//   if_id_next_pc    out  address after the last word of the instruction
//   if_id_valid      out  IF/ID holds a real instruction

module fetch_stage #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               jump_taken,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               interrupt_signal,
    input  logic               int_ack,
    output logic               int_pending,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_next_pc,
    output logic               if_id_valid
);

    typedef enum logic {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_op_q, hold_op_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [ADDR_W-1:0]  id_next_pc_q, id_next_pc_d;
    logic               valid_q, valid_d;
    logic               int_pending_q, int_pending_d;

    logic               is_two_word;
    logic [ADDR_W-1:0]  pc_plus1;

    // Opcodes 011x_xxxx_xxxx_xxxx carry a trailing 16-bit immediate word.
    assign is_two_word = (imem_data[INSTR_W-1:INSTR_W-3] == 3'b011);
    // Natural wrap modulo 2^ADDR_W.
    assign pc_plus1    = pc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_OP;
            pc_q          <= RESET_PC;
            hold_op_q     <= '0;
            hold_pc_q     <= '0;
            instr_q       <= '0;
            imm_q         <= '0;
            id_pc_q       <= '0;
            id_next_pc_q  <= '0;
            valid_q       <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_op_q     <= hold_op_d;
            hold_pc_q     <= hold_pc_d;
            instr_q       <= instr_d;
            imm_q         <= imm_d;
            id_pc_q       <= id_pc_d;
            id_next_pc_q  <= id_next_pc_d;
            valid_q       <= valid_d;
            int_pending_q <= int_pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_op_d    = hold_op_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        id_pc_d      = id_pc_q;
        id_next_pc_d = id_next_pc_q;
        valid_d      = valid_q;

        if (jump_taken) begin
            // Any half-assembled two-word instruction is abandoned; the hold
            // registers are simply never consumed because the FSM restarts.
            pc_d         = jump_target;
            state_d      = FETCH_OP;
            instr_d      = '0;
            imm_d        = '0;
            id_pc_d      = '0;
            id_next_pc_d = '0;
            valid_d      = 1'b0;
        end else if (flush) begin
            instr_d      = '0;
            imm_d        = '0;
            id_pc_d      = '0;
            id_next_pc_d = '0;
            valid_d      = 1'b0;
            // Mid two-word fetch: rewind to the opcode so it is read again.
            if (state_q == FETCH_IMM) begin
                pc_d    = hold_pc_q;
                state_d = FETCH_OP;
            end
        end else if (!stall) begin
            unique case (state_q)
                FETCH_OP: begin
                    pc_d = pc_plus1;
                    if (is_two_word) begin
                        hold_op_d    = imem_data;
                        hold_pc_d    = pc_q;
                        state_d      = FETCH_IMM;
                        // Bubble while the immediate word is fetched.
                        instr_d      = '0;
                        imm_d        = '0;
                        id_pc_d      = '0;
                        id_next_pc_d = '0;
                        valid_d      = 1'b0;
                    end else begin
                        instr_d      = imem_data;
                        imm_d        = '0;
                        id_pc_d      = pc_q;
                        id_next_pc_d = pc_plus1;
                        valid_d      = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    pc_d         = pc_plus1;
                    state_d      = FETCH_OP;
                    instr_d      = hold_op_q;
                    imm_d        = imem_data;
                    id_pc_d      = hold_pc_q;
                    id_next_pc_d = pc_plus1;
                    valid_d      = 1'b1;
                end
                default: begin
                    state_d = FETCH_OP;
                end
            endcase
        end
    end

    // A request arriving in the same cycle as an ack wins, so it is not lost.
    always_comb begin
        int_pending_d = interrupt_signal | (int_pending_q & ~int_ack);
    end

    assign imem_addr     = pc_q;
    assign int_pending   = int_pending_q;
    assign if_id_instr   = instr_q;
    assign if_id_imm     = imm_q;
    assign if_id_pc      = id_pc_q;
    assign if_id_next_pc = id_next_pc_q;
    assign if_id_valid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        flush;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        interrupt_signal;
    logic        int_ack;
    logic        int_pending;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_next_pc;
    logic        if_id_valid;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:255];

    assign imem_data = mem[imem_addr[7:0]];

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .INSTR_W(16), .RESET_PC(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .stall            (stall),
        .flush            (flush),
        .jump_taken       (jump_taken),
        .jump_target      (jump_target),
        .interrupt_signal (interrupt_signal),
        .int_ack          (int_ack),
        .int_pending      (int_pending),
        .if_id_instr      (if_id_instr),
        .if_id_imm        (if_id_imm),
        .if_id_pc         (if_id_pc),
        .if_id_next_pc    (if_id_next_pc),
        .if_id_valid      (if_id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] m,
                        input logic [31:0] p, input logic [31:0] n);
        exp_t e;
        e.instr = i; e.imm = m; e.pc = p; e.npc = n;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1 time unit later, check valid and pop the
    // scoreboard whenever the DUT presents an instruction.
    task automatic step(input logic ev);
        exp_t e;
        @(posedge clk);
        #1;
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, ev});
        if (if_id_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_instr", {16'd0, if_id_instr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("if_id_instr",   {16'd0, if_id_instr}, {16'd0, e.instr});
                chk("if_id_imm",     {16'd0, if_id_imm},   {16'd0, e.imm});
                chk("if_id_pc",      if_id_pc,             e.pc);
                chk("if_id_next_pc", if_id_next_pc,        e.npc);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0; flush = 1'b0; jump_taken = 1'b0;
        step(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; jump_taken = 1'b0;
        jump_target = 32'd0; interrupt_signal = 1'b0; int_ack = 1'b0;

        // Reset state and back-to-back one-word instructions.
        mem[32] = 16'h1234; mem[33] = 16'h2000; mem[34] = 16'h0001;
        step(1'b0);
        do_reset();
        chk("rst_imem_addr", imem_addr, 32'd32);
        chk("rst_int_pending", {31'd0, int_pending}, 32'd0);
        chk("rst_instr", {16'd0, if_id_instr}, 32'd0);
        chk("rst_next_pc", if_id_next_pc, 32'd0);
        push(16'h1234, 16'h0, 32'd32, 32'd33); step(1'b1);
        push(16'h2000, 16'h0, 32'd33, 32'd34); step(1'b1);
        push(16'h0001, 16'h0, 32'd34, 32'd35); step(1'b1);

        // Two-word instruction, unstalled.
        mem[32] = 16'h6001; mem[33] = 16'hBEEF;
        do_reset();
        step(1'b0);
        chk("tw_bubble_addr", imem_addr, 32'd33);
        push(16'h6001, 16'hBEEF, 32'd32, 32'd34); step(1'b1);
        chk("tw_done_addr", imem_addr, 32'd34);

        // Stall for three cycles in FETCH_IMM.
        do_reset();
        step(1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            chk("stall_addr", imem_addr, 32'd33);
        end
        stall = 1'b0;
        push(16'h6001, 16'hBEEF, 32'd32, 32'd34); step(1'b1);

        // Jump while in FETCH_IMM discards the held opcode.
        mem[0] = 16'h1111;
        do_reset();
        step(1'b0);
        jump_taken = 1'b1; jump_target = 32'h100;
        step(1'b0);
        jump_taken = 1'b0;
        chk("jump_addr", imem_addr, 32'h100);
        chk("jump_instr", {16'd0, if_id_instr}, 32'd0);
        chk("jump_pc", if_id_pc, 32'd0);
        push(16'h1111, 16'h0, 32'h100, 32'h101); step(1'b1);

        // Flush in FETCH_IMM rewinds to the opcode at 40.
        mem[40] = 16'h7ABC; mem[41] = 16'h5555;
        jump_taken = 1'b1; jump_target = 32'd40;
        step(1'b0);
        jump_taken = 1'b0;
        chk("flush_start_addr", imem_addr, 32'd40);
        step(1'b0);
        chk("flush_imm_addr", imem_addr, 32'd41);
        flush = 1'b1;
        step(1'b0);
        chk("flush_rewind_addr", imem_addr, 32'd40);
        flush = 1'b0;
        step(1'b0);
        push(16'h7ABC, 16'h5555, 32'd40, 32'd42); step(1'b1);

        // Interrupt latch, with fetch held by flush in FETCH_OP.
        flush = 1'b1;
        interrupt_signal = 1'b1;
        step(1'b0);
        chk("int_set", {31'd0, int_pending}, 32'd1);
        chk("flush_op_addr", imem_addr, 32'd42);
        interrupt_signal = 1'b0;
        step(1'b0);
        chk("int_hold", {31'd0, int_pending}, 32'd1);
        interrupt_signal = 1'b1; int_ack = 1'b1;
        step(1'b0);
        chk("int_set_and_ack", {31'd0, int_pending}, 32'd1);
        interrupt_signal = 1'b0;
        step(1'b0);
        chk("int_ack_clear", {31'd0, int_pending}, 32'd0);
        int_ack = 1'b0;
        flush = 1'b0;

        // PC wrap at the top of the address space.
        mem[255] = 16'h2222;
        jump_taken = 1'b1; jump_target = 32'hFFFF_FFFF;
        step(1'b0);
        jump_taken = 1'b0;
        push(16'h2222, 16'h0, 32'hFFFF_FFFF, 32'h0); step(1'b1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset mid two-word fetch restarts cleanly in FETCH_OP.
        mem[32] = 16'h6001; mem[33] = 16'hBEEF;
        do_reset();
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("midrst_addr", imem_addr, 32'd32);
        step(1'b0);
        push(16'h6001, 16'hBEEF, 32'd32, 32'd34); step(1'b1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
